mul_sequencer: RTL and testbench
================================

MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand and result width in bits.
REQ-002 SHALL have parameter MUL_CODE, default 4'b0011, ALU control code that selects multiply.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port valid_i, input, 1, the EX-stage instruction is valid.
REQ-006 SHALL have port flush_i, input, 1, pipeline flush that aborts any multiply in progress.
REQ-007 SHALL have port ALUCtrl_i, input, 4, ALU control code from the ALU control decoder.
REQ-008 SHALL have port ALUJrCtrl_i, input, 1, jr flag from the ALU control decoder.
REQ-009 SHALL have port src1_i, input, DATA_W, multiplicand.
REQ-010 SHALL have port src2_i, input, DATA_W, multiplier.
REQ-011 SHALL have port stall_o, output, 1, holds the PC and IF/ID/EX registers.
REQ-012 SHALL have port done_o, output, 1, one-cycle pulse marking result_o as newly valid.
REQ-013 SHALL have port result_o, output, DATA_W, low DATA_W bits of the product.

Function
REQ-014 SHALL define start = valid_i & (ALUCtrl_i==MUL_CODE) & ~ALUJrCtrl_i & ~flush_i.
- jr shares code 0011 with mul, so jr SHALL never start a multiply.
REQ-015 SHALL implement an FSM with exactly three states: IDLE, BUSY, DONE.
REQ-016 In IDLE with start=1, SHALL do all of the following:
- latch src1_i and src2_i;
- clear the accumulator and the iteration counter;
- go to BUSY.
- Exception: if either operand is 0, go directly to DONE with product 0.
REQ-017 In IDLE with start=0, SHALL remain in IDLE and leave all registers unchanged.
REQ-018 In BUSY, SHALL perform one radix-2 shift-add step per cycle:
- if the multiplier LSB is 1, add the multiplicand to the accumulator, mod 2^DATA_W;
- shift the multiplicand left by 1 and the multiplier right by 1;
- increment the counter.
REQ-019 SHALL leave BUSY for DONE after exactly DATA_W steps, with no early exit inside BUSY.
REQ-020 In DONE, SHALL register the accumulator into result_o, pulse done_o for one cycle, and go to IDLE unconditionally.
- DONE SHALL NOT restart the multiply, even though the same mul is still presented in EX.
REQ-021 SHALL drive stall_o combinationally: stall_o = (IDLE & start) | BUSY, and stall_o SHALL be 0 in DONE.
REQ-022 Latency, counting the request cycle as cycle 0:
- stall_o high in cycles 0..DATA_W;
- done_o high in cycle DATA_W+1;
- zero-operand case: stall_o high in cycle 0 only, done_o in cycle 1.
REQ-023 SHALL make result_o equal (src1_i*src2_i) mod 2^DATA_W.
- Signedness SHALL have no effect on the result.
REQ-024 SHALL hold result_o unchanged from DONE until the next DONE.
REQ-025 flush_i=1 in BUSY SHALL abort the multiply:
- next state IDLE;
- stall_o drops in the same cycle;
- done_o stays 0 and result_o is unchanged.
REQ-026 flush_i=1 in DONE SHALL NOT suppress done_o or the result_o update.
REQ-027 While BUSY, SHALL ignore changes on valid_i, ALUCtrl_i, src1_i and src2_i.

Reset
REQ-028 rst_i=1 SHALL immediately, without waiting for a clock edge, force:
- state IDLE;
- counter, accumulator and operand registers 0;
- result_o=0 and done_o=0.
REQ-029 While rst_i=1, stall_o SHALL be 0.
REQ-030 Reset asserted mid-BUSY SHALL abandon the operation with no done_o after release.

Verification
REQ-031 The bench SHALL cover: start 7*6 at cycle 0 -> stall_o high cycles 0-32, done_o at cycle 33, result_o=42.
REQ-032 The bench SHALL cover: 0xFFFFFFFF*2 -> result_o=0xFFFFFFFE; 0x80000000*0x80000000 -> result_o=0.
REQ-033 The bench SHALL cover: src2_i=0 with src1_i=0x1234 -> stall_o high in cycle 0 only, done_o at cycle 1, result_o=0.
REQ-034 The bench SHALL cover: ALUCtrl_i=0011 with ALUJrCtrl_i=1, and separately ALUCtrl_i=0010 -> stall_o=0, done_o never asserts.
REQ-035 The bench SHALL cover: flush_i at cycle 10 of a 9*9 multiply -> stall_o low in cycle 10, no done_o, result_o unchanged; then 3*5 -> result_o=15 after 33 cycles.
REQ-036 The bench SHALL cover: rst_i pulsed mid-cycle at cycle 20 of a multiply -> result_o, done_o and stall_o 0 before the next edge, FSM in IDLE after release.

Source files
------------

// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier for the EX stage.
// Stalls the pipeline while iterating and pulses done_o when result_o is refreshed.
module mul_sequencer #(
    parameter int unsigned DATA_W   = 32,
    parameter logic [3:0]  MUL_CODE = 4'b0011
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic [3:0]        ALUCtrl_i,
    input  logic              ALUJrCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] acc_step;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              start;
    logic              zero_op;
    logic              last_step;

    // jr shares the mul ALU code, so it must be excluded explicitly
    assign start     = valid_i & (ALUCtrl_i == MUL_CODE) & ~ALUJrCtrl_i & ~flush_i;
    assign zero_op   = (src1_i == '0) | (src2_i == '0);
    assign last_step = (cnt_q == CntW'(DATA_W - 1));
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = zero_op ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (flush_i) begin
                    state_d = StIdle;
                end else if (last_step) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Result is captured on the edge into DONE so it is valid while done_o is high
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (state_q == StIdle && start) begin
            mcand_d  = src1_i;
            mplier_d = src2_i;
            acc_d    = '0;
            cnt_d    = '0;
            if (zero_op) begin
                result_d = '0;
            end
        end else if (state_q == StBusy && !flush_i) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (last_step) begin
                result_d = acc_step;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        stall_o  = ~rst_i & (((state_q == StIdle) & start) |
                             ((state_q == StBusy) & ~flush_i));
        done_o   = (state_q == StDone);
        result_o = result_q;
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: latency, wrap-around products,
// zero shortcut, jr/non-mul rejection, flush abort and asynchronous reset.
module tb_mul_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [3:0]  ALUCtrl_i;
    logic        ALUJrCtrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    mul_sequencer #(
        .DATA_W   (32),
        .MUL_CODE (4'b0011)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .flush_i     (flush_i),
        .ALUCtrl_i   (ALUCtrl_i),
        .ALUJrCtrl_i (ALUJrCtrl_i),
        .src1_i      (src1_i),
        .src2_i      (src2_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .result_o    (result_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Entered and left at posedge+1; request presented in cycle 0, done expected in cycle lat
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input int lat, input logic [31:0] prev);
        valid_i   = 1'b1;
        ALUCtrl_i = 4'b0011;
        src1_i    = a;
        src2_i    = b;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk_i);
            chk($sformatf("stall_c%0d", c), {31'd0, stall_o}, 32'd1);
            chk($sformatf("nodone_c%0d", c), {31'd0, done_o}, 32'd0);
            if (c == 0) chk("result_held_c0", result_o, prev);
            step();
            // operands must be ignored once the multiply is under way
            src1_i = ~a;
            src2_i = b + 32'd1;
        end
        @(negedge clk_i);
        chk("done_pulse", {31'd0, done_o}, 32'd1);
        chk("stall_in_done", {31'd0, stall_o}, 32'd0);
        chk("result", result_o, exp);
        valid_i = 1'b0;
        step();
        @(negedge clk_i);
        chk("done_one_cycle", {31'd0, done_o}, 32'd0);
        chk("result_after_done", result_o, exp);
        step();
    endtask

    initial begin
        rst_i       = 1'b1;
        valid_i     = 1'b0;
        flush_i     = 1'b0;
        ALUCtrl_i   = 4'b0000;
        ALUJrCtrl_i = 1'b0;
        src1_i      = '0;
        src2_i      = '0;
        #2;
        chk("rst_result", result_o, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_stall", {31'd0, stall_o}, 32'd0);
        step();
        rst_i = 1'b0;
        step();

        run_mul(32'd7, 32'd6, 32'd42, 33, 32'd0);
        run_mul(32'h8000_0000, 32'h8000_0000, 32'd0, 33, 32'd42);
        run_mul(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 33, 32'd0);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFE);
        run_mul(32'd123, 32'd1000, 32'd123000, 33, 32'd1);

        // jr uses the mul code but must never start
        valid_i     = 1'b1;
        ALUCtrl_i   = 4'b0011;
        ALUJrCtrl_i = 1'b1;
        src1_i      = 32'd5;
        src2_i      = 32'd5;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("jr_stall", {31'd0, stall_o}, 32'd0);
            chk("jr_done", {31'd0, done_o}, 32'd0);
            step();
        end
        ALUJrCtrl_i = 1'b0;
        ALUCtrl_i   = 4'b0010;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("add_stall", {31'd0, stall_o}, 32'd0);
            chk("add_done", {31'd0, done_o}, 32'd0);
            step();
        end
        valid_i = 1'b0;
        chk("nonmul_result", result_o, 32'd123000);

        run_mul(32'h1234, 32'd0, 32'd0, 1, 32'd123000);
        run_mul(32'd11, 32'd13, 32'd143, 33, 32'd0);

        // flush at cycle 10 of 9*9
        valid_i   = 1'b1;
        ALUCtrl_i = 4'b0011;
        src1_i    = 32'd9;
        src2_i    = 32'd9;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            chk("flush_pre_stall", {31'd0, stall_o}, 32'd1);
            step();
        end
        flush_i = 1'b1;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_stall_drop", {31'd0, stall_o}, 32'd0);
        step();
        flush_i = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            chk("flush_no_done", {31'd0, done_o}, 32'd0);
            chk("flush_idle", {31'd0, stall_o}, 32'd0);
            step();
        end
        chk("flush_result_held", result_o, 32'd143);
        run_mul(32'd3, 32'd5, 32'd15, 33, 32'd143);

        // asynchronous reset mid-multiply at cycle 20
        valid_i   = 1'b1;
        ALUCtrl_i = 4'b0011;
        src1_i    = 32'd10;
        src2_i    = 32'd11;
        repeat (20) step();
        @(negedge clk_i);
        chk("pre_rst_stall", {31'd0, stall_o}, 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_done", {31'd0, done_o}, 32'd0);
        chk("midrst_stall", {31'd0, stall_o}, 32'd0);
        step();
        chk("rst_held_stall", {31'd0, stall_o}, 32'd0);
        valid_i = 1'b0;
        rst_i   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            chk("post_rst_done", {31'd0, done_o}, 32'd0);
            chk("post_rst_idle", {31'd0, stall_o}, 32'd0);
            step();
        end
        run_mul(32'd2, 32'd3, 32'd6, 33, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
